// File: rtl/gf467_pkg.sv
// Shared constants, widths and FSM encoding for the GF(467) modular inverter.
// Contents: GF_Q/GF_MU/GF_EXP field constants, datapath widths, state_t enum.
package gf467_pkg;

    localparam int unsigned GF_Q   = 467;   // prime modulus
    localparam int unsigned GF_MU  = 561;   // floor(2^18 / GF_Q)
    localparam int unsigned GF_EXP = 465;   // GF_Q - 2, Fermat inverse exponent

    localparam int unsigned DW   = 9;       // residue / operand width
    localparam int unsigned PW   = 18;      // full product width
    localparam int unsigned QW   = 20;      // q1*MU intermediate width
    localparam int unsigned IDXW = 4;       // exponent bit index width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SQR,
        ST_MUL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/modinv_for_467_if.sv
// Operand/result handshake bundle for modinv_for_467.
// master: drives in_valid, din_a, out_ready.  slave: drives in_ready,
// out_valid, dout_r, zero_err.
interface modinv_for_467_if;
    import gf467_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] din_a;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout_r;
    logic          zero_err;

    modport master (
        output in_valid, din_a, out_ready,
        input  in_ready, out_valid, dout_r, zero_err
    );

    modport slave (
        input  in_valid, din_a, out_ready,
        output in_ready, out_valid, dout_r, zero_err
    );

endinterface

// File: rtl/modinv_for_467_barrett_red.sv
// Combinational Barrett reduction of an 18-bit value (< Q^2) modulo Q.
// Ports: i_x - 18-bit product, o_r - residue in 0..Q-1.
module barrett_red_18_467
    import gf467_pkg::*;
#(
    parameter int unsigned Q  = GF_Q,
    parameter int unsigned MU = GF_MU
) (
    input  logic [PW-1:0] i_x,
    output logic [DW-1:0] o_r
);

    logic [9:0]    w_q1;
    logic [QW-1:0] w_q1mu;
    logic [9:0]    w_q3;
    logic [PW-1:0] w_q3q;
    logic [PW-1:0] w_r0;
    logic [PW-1:0] w_r1;
    logic [PW-1:0] w_r2;

    // Quotient estimate undershoots by at most 2, so two conditional subtracts suffice.
    always_comb begin
        w_q1   = 10'(i_x >> 8);
        w_q1mu = QW'(w_q1) * QW'(MU);
        w_q3   = 10'(w_q1mu >> 10);
        w_q3q  = PW'(w_q3) * PW'(Q);
        w_r0   = i_x - w_q3q;
        w_r1   = (w_r0 >= PW'(Q)) ? w_r0 - PW'(Q) : w_r0;
        w_r2   = (w_r1 >= PW'(Q)) ? w_r1 - PW'(Q) : w_r1;
        o_r    = DW'(w_r2);
    end

endmodule

// File: rtl/modinv_for_467.sv
// Fixed-latency modular inverse a^(Q-2) mod Q by left-to-right square-and-multiply.
// Ports: clk, rst_n (async active-low), io_bus (slave side of modinv_for_467_if).
module modinv_for_467
    import gf467_pkg::*;
#(
    parameter int unsigned Q   = GF_Q,
    parameter int unsigned MU  = GF_MU,
    parameter int unsigned EXP = GF_EXP
) (
    input  logic               clk,
    input  logic               rst_n,
    modinv_for_467_if.slave    io_bus
);

    localparam logic [DW-1:0]   EXP_BITS = DW'(EXP);
    localparam logic [IDXW-1:0] BIT_TOP  = IDXW'(DW - 1);

    state_t          r_state;
    logic [DW-1:0]   r_acc;
    logic [DW-1:0]   r_base;
    logic [IDXW-1:0] r_bit_idx;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [DW-1:0]   r_dout;
    logic            r_zero;

    logic [DW-1:0]   w_op;
    logic [PW-1:0]   w_prod;
    logic [DW-1:0]   w_red;
    logic [DW-1:0]   w_din_red;

    // Single shared multiplier: squares acc in SQR, multiplies by base in MUL.
    always_comb begin
        w_op      = (r_state == ST_MUL) ? r_base : r_acc;
        w_prod    = PW'(r_acc) * PW'(w_op);
        w_din_red = (io_bus.din_a >= DW'(Q)) ? io_bus.din_a - DW'(Q) : io_bus.din_a;
    end

    barrett_red_18_467 #(
        .Q  (Q),
        .MU (MU)
    ) u_red (
        .i_x (w_prod),
        .o_r (w_red)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= DW'(1);
            r_base      <= '0;
            r_bit_idx   <= BIT_TOP;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_base     <= w_din_red;
                        r_acc      <= DW'(1);
                        r_bit_idx  <= BIT_TOP;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SQR;
                    end
                end
                ST_SQR: begin
                    r_acc <= w_red;
                    if (EXP_BITS[r_bit_idx]) begin
                        r_state <= ST_MUL;
                    end else if (r_bit_idx == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_dout      <= w_red;
                        r_zero      <= (r_base == '0);
                    end else begin
                        r_bit_idx <= r_bit_idx - IDXW'(1);
                    end
                end
                ST_MUL: begin
                    r_acc <= w_red;
                    if (r_bit_idx == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_dout      <= w_red;
                        r_zero      <= (r_base == '0);
                    end else begin
                        r_bit_idx <= r_bit_idx - IDXW'(1);
                        r_state   <= ST_SQR;
                    end
                end
                ST_DONE: begin
                    if (io_bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_dout      <= '0;
                        r_zero      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.dout_r    = r_dout;
    assign io_bus.zero_err  = r_zero;

endmodule

// File: tb/tb_modinv_for_467.sv
module tb_modinv_for_467;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    modinv_for_467_if bus ();

    modinv_for_467 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    typedef struct {
        logic [8:0] a;
        int         er;
        int         ez;
        int         hold;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Inverse found by exhaustive search over the field, 0 for the zero residue.
    function automatic int ref_inv(input int a);
        int b;
        b = a % 467;
        if (b == 0) return 0;
        for (int x = 1; x < 467; x++)
            if ((b * x) % 467 == 1) return x;
        return -1;
    endfunction

    task automatic do_op(input logic [8:0] a, input int hold, input bit noise,
                         output logic [8:0] r, output logic z, output int lat);
        int guard;
        bit stable;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 0, 1);
        bus.din_a    = a;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.din_a    = 9'($urandom);
        chk("busy_in_ready", int'(bus.in_ready), 0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (noise) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = 1'($urandom_range(0, 1));
                bus.din_a     = 9'($urandom);
            end
            @(posedge clk); #1; lat++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        r = bus.dout_r;
        z = bus.zero_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.dout_r !== r || bus.zero_err !== z ||
                bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) chk("done_hold_stable", int'(stable), 1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release_out_valid", int'(bus.out_valid), 0);
        chk("release_in_ready", int'(bus.in_ready), 1);
    endtask

    task automatic watch_silent(input string nm, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk(nm, int'(seen), 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
        chk({nm, "_out_valid"}, int'(bus.out_valid), 0);
        chk({nm, "_dout_r"}, int'(bus.dout_r), 0);
        chk({nm, "_zero_err"}, int'(bus.zero_err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] r;
        logic       z;
        int         lat;
        int         a;

        vecs[0] = '{9'd2,   234, 0, 0};
        vecs[1] = '{9'd3,   156, 0, 1};
        vecs[2] = '{9'd466, 466, 0, 0};
        vecs[3] = '{9'd1,   1,   0, 2};
        vecs[4] = '{9'd469, 234, 0, 0};
        vecs[5] = '{9'd0,   0,   1, 3};
        vecs[6] = '{9'd467, 0,   1, 0};
        vecs[7] = '{9'd511, 138, 0, 0};
        vecs[8] = '{9'd5,   187, 0, 10};
        vecs[9] = '{9'd2,   234, 0, 10};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.din_a     = '0;
        bus.out_ready = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors; the last two hold DONE for 10 cycles with noise during compute.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].hold, (i >= 8), r, z, lat);
            chk($sformatf("vec%0d_latency", i), lat, 14);
            chk($sformatf("vec%0d_dout_r", i), int'(r), vecs[i].er);
            chk($sformatf("vec%0d_zero_err", i), int'(z), vecs[i].ez);
        end

        // Reset at cycle 7 of a computation.
        bus.din_a    = 9'd7;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        #2;
        rst_n = 1'b1;
        watch_silent("midreset_no_emit", 20);
        do_op(9'd5, 0, 1'b0, r, z, lat);
        chk("after_midreset_latency", lat, 14);
        chk("after_midreset_dout_r", int'(r), 187);

        // Reset while holding a result in DONE.
        bus.din_a    = 9'd9;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (16) begin @(posedge clk); #1; end
        chk("done_before_reset", int'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("donereset");
        #2;
        rst_n = 1'b1;
        watch_silent("donereset_no_emit", 20);

        // Sweep of all nonzero residues with random hold and handshake noise.
        for (int i = 1; i < 467; i++) begin
            do_op(9'(i), $urandom_range(0, 2), 1'b1, r, z, lat);
            chk($sformatf("sweep%0d_latency", i), lat, 14);
            chk($sformatf("sweep%0d_dout_r", i), int'(r), ref_inv(i));
            chk($sformatf("sweep%0d_product", i), (i * int'(r)) % 467, 1);
            chk($sformatf("sweep%0d_zero_err", i), int'(z), 0);
        end

        // Random unreduced operands 467..511.
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(467, 511);
            do_op(9'(a), $urandom_range(0, 3), 1'b1, r, z, lat);
            chk($sformatf("hi%0d_latency", a), lat, 14);
            chk($sformatf("hi%0d_dout_r", a), int'(r), ref_inv(a));
            chk($sformatf("hi%0d_zero_err", a), int'(z), (a % 467 == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/modinv_for_467.md
MODINV_FOR_467 -- requirements
Module: modinv_for_467

Interface
REQ-001 Parameter Q, default 467, modulus (prime, 9 bits).
REQ-002 Parameter MU, default 561, Barrett constant floor(2^18/Q).
REQ-003 Parameter EXP, default 465, exponent Q-2, 9 bits, binary 111010001.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  din_a is presented.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 din_a  input  9  operand; values 0..511 accepted.
REQ-009 out_valid  output  1  dout_r and zero_err are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 dout_r  output  9  modular inverse of din_a mod Q, range 0..Q-1.
REQ-012 zero_err  output  1  operand was congruent to 0; dout_r is 0.

Function
REQ-013 Result SHALL be din_a^EXP mod Q (Fermat inverse); a*dout_r mod Q = 1 for every nonzero residue a.
REQ-014 FSM states: IDLE, SQR, MUL, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE, in_valid=1: capture base = din_a >= Q ? din_a-Q : din_a; acc <= 1; bit_idx <= 8; go to SQR.
REQ-017 SQR: acc <= red(acc*acc); if EXP[bit_idx]=1 go to MUL; else if bit_idx=0 go to DONE; else bit_idx decrements and FSM stays in SQR.
REQ-018 MUL: acc <= red(acc*base); if bit_idx=0 go to DONE; else bit_idx decrements and FSM goes to SQR.
REQ-019 Fixed latency: handshake at edge N -> out_valid=1 after edge N+14 (9 SQR + 5 MUL cycles), independent of operand.
REQ-020 DONE: out_valid=1; dout_r=acc and zero_err=(base==0), both held stable until out_ready=1.
REQ-021 DONE with out_ready=1: go to IDLE at that edge; in_ready rises the next cycle; no same-cycle accept.
REQ-022 in_valid in SQR/MUL/DONE SHALL be ignored; no capture, no effect on the result.
REQ-023 out_ready outside DONE SHALL be ignored.
REQ-024 Operand 0 (or 467) SHALL complete normally with the same latency, dout_r=0, zero_err=1.
REQ-025 red(x), for x < Q^2 (18 bits): q1 = x>>8; q3 = (q1*MU)>>10; r = x - q3*Q; subtract Q at most twice until r < Q.
REQ-026 Products SHALL be 18 bits wide and the q1*MU intermediate at least 20 bits wide; no truncation before reduction.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, acc=1, base=0, bit_idx=8, out_valid=0, dout_r=0, zero_err=0, in_ready=1.
REQ-028 Reset mid-computation or in DONE SHALL discard the operation; nothing is emitted after release.
REQ-029 First accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Q, MU, EXP, the state enum and widths SHALL reside in shared package gf467_pkg.
REQ-031 Reduction SHALL be one combinational sub-module, barrett_red_18_467, with 18-bit input and 9-bit output, instantiated once and shared by SQR and MUL through an operand mux.
REQ-032 No multicycle paths; one multiply plus reduction per cycle.

Verification
REQ-033 din_a=2 -> after 14 cycles dout_r=234, zero_err=0.
REQ-034 din_a=3 -> dout_r=156; din_a=466 -> dout_r=466; din_a=1 -> dout_r=1.
REQ-035 din_a=469 (reduced to 2) -> dout_r=234; din_a=0 -> dout_r=0, zero_err=1.
REQ-036 out_ready held 0 for 10 cycles in DONE -> out_valid and dout_r stay stable and in_ready stays 0; in_valid pulses during the computation are ignored.
REQ-037 rst_n pulsed low at cycle 7 of a computation -> outputs immediately take their reset values; a new accept with din_a=5 -> dout_r=187.
REQ-038 Exhaustive sweep of din_a 1..466 against a reference model -> (a*dout_r) mod 467 = 1 every time, latency always 14.
